// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
//   Scans a 4x4 hex keypad, debounces presses and shifts each accepted
//   hex digit into a 16-bit entry register.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   kp_row[3:0]  keypad rows, active-low, asynchronous (pulled up externally)
//   kp_col[3:0]  keypad column drive, active-low, exactly one bit low
//   clear        zeroes entry_value on the next edge (priority over a shift)
//   entry_value  shifted hex entry, newest digit in [3:0]
//   key_valid    one-cycle pulse per accepted key
//   key_code     hex value of the last accepted key
//   state_dbg    debounce FSM state (IDLE=0, DEBOUNCE=1, HELD=2)
//
// Handshake: key_valid is a strobe with no ready; on the cycle it is high,
// key_code and entry_value already carry the accepted digit.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  kp_row,
  output logic [3:0]  kp_col,
  input  logic        clear,
  output logic [15:0] entry_value,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [1:0]  state_dbg
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   hits_q, hits_d;
  logic          eval_q, eval_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]   entry_q, entry_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;

  logic          slot_end;
  logic [4:0]    n_low;
  logic [3:0]    low_idx;
  logic [3:0]    scan_code;
  logic          accept;

  // Hit index is {column, row}; returns the printed legend of that key.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;
      4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
      4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
      4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;
      4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
      4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;
      4'hE: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  // Scan timing and per-scan hit capture.
  always_comb begin
    slot_end = (div_q == DW'(SCAN_DIV - 1));
    div_d    = slot_end ? '0 : div_q + 1'b1;
    col_d    = slot_end ? col_q + 2'd1 : col_q;
    hits_d   = hits_q;
    if (slot_end) begin
      // Column 0 starts a fresh scan, so earlier hits are dropped there.
      if (col_q == 2'd0) hits_d = '0;
      for (int r = 0; r < 4; r++) hits_d[{col_q, 2'(r)}] = ~row_s2_q[r];
    end
    eval_d = slot_end && (col_q == 2'd3);
  end

  // Classify the completed scan: count of low positions and the last one.
  always_comb begin
    n_low   = '0;
    low_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits_q[i]) begin
        n_low   = n_low + 5'd1;
        low_idx = 4'(i);
      end
    end
    scan_code = key_map(low_idx);
  end

  // Debounce FSM, advanced only on the scan-evaluation cycle.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    accept  = 1'b0;
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (n_low == 5'd1) begin
            cand_d = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (n_low == 5'd1) begin
            if (scan_code == cand_q) begin
              if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                accept  = 1'b1;
                state_d = HELD;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              cand_d = scan_code;
              cnt_d  = CW'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // cnt_q counts consecutive empty scans here (release debounce).
          if (n_low == 5'd0) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    if (clear)       entry_d = '0;
    else if (accept) entry_d = {entry_q[11:0], cand_d};
    else             entry_d = entry_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_q       <= '0;
      col_q       <= '0;
      hits_q      <= '0;
      eval_q      <= 1'b0;
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      entry_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      row_s1_q    <= kp_row;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      eval_q      <= eval_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign kp_col      = ~(4'b0001 << col_q);
  assign entry_value = entry_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
module tb_hex_keypad_entry;

  localparam int SD = 4;
  localparam int DS = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  kp_row, kp_col, key_code;
  logic [15:0] entry_value;
  logic        key_valid;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  hex_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .kp_row(kp_row), .kp_col(kp_col),
    .clear(clear), .entry_value(entry_value), .key_valid(key_valid),
    .key_code(key_code), .state_dbg(state_dbg)
  );

  // ---------------- keypad model ----------------
  // keys[k] = 1 means the key labelled hex k is held down.
  logic [15:0] keys = '0;
  logic [3:0]  kmap [0:3][0:3];   // [row][col] -> legend

  initial begin
    kmap[0][0] = 4'h1; kmap[0][1] = 4'h2; kmap[0][2] = 4'h3; kmap[0][3] = 4'hA;
    kmap[1][0] = 4'h4; kmap[1][1] = 4'h5; kmap[1][2] = 4'h6; kmap[1][3] = 4'hB;
    kmap[2][0] = 4'h7; kmap[2][1] = 4'h8; kmap[2][2] = 4'h9; kmap[2][3] = 4'hC;
    kmap[3][0] = 4'h0; kmap[3][1] = 4'hF; kmap[3][2] = 4'hE; kmap[3][3] = 4'hD;
  end

  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_col[c] && keys[kmap[r][c]]) kp_row[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];   // {key_valid, key_code, entry_value}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (per-scan rules) ----------------
  logic        m_held;
  int          m_streak_len, m_none_len;
  logic [3:0]  m_streak_code, m_code;
  logic [15:0] m_entry, prev_keys;
  logic        prev_valid;

  task automatic model_reset();
    m_held = 0; m_streak_len = 0; m_none_len = 0; m_streak_code = 0;
    m_code = 0; m_entry = 0; prev_keys = 0; prev_valid = 0;
  endtask

  task automatic model_eval(input logic [15:0] k, output logic acc, output logic [3:0] code);
    int n;
    logic [3:0] kc;
    n = $countones(k);
    acc = 0; code = 0; kc = 0;
    for (int i = 0; i < 16; i++) if (k[i]) kc = 4'(i);
    if (m_held) begin
      m_none_len = (n == 0) ? m_none_len + 1 : 0;
      if (m_none_len == DS) begin m_held = 0; m_streak_len = 0; end
    end else if (n == 1) begin
      m_streak_len  = (m_streak_len > 0 && m_streak_code == kc) ? m_streak_len + 1 : 1;
      m_streak_code = kc;
      if (m_streak_len >= DS) begin
        acc = 1; code = kc; m_held = 1; m_none_len = 0; m_streak_len = 0;
      end
    end else begin
      m_streak_len = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] kb(input int n);
    logic [15:0] one;
    one = 16'h0001;
    return one << n;
  endfunction

  // Called at #1 after the edge that starts column 0. Applies a key set for
  // one full scan; the outputs seen on the first cycle reflect the previous
  // scan's evaluation and are returned to the caller.
  task automatic do_scan(input logic [15:0] k, input logic clr,
                         output logic obs_v, output logic [3:0] obs_code,
                         output logic [15:0] obs_entry);
    logic acc;
    logic [3:0] c, exp_col;
    logic [20:0] e;
    int bad_col, extra;
    keys = k;
    clear = clr;
    acc = 0; c = 0;
    if (prev_valid) model_eval(prev_keys, acc, c);
    if (acc) m_code = c;
    if (clr)      m_entry = 16'h0;
    else if (acc) m_entry = {m_entry[11:0], c};
    exp_q.push_back({acc, m_code, m_entry});
    bad_col = 0; extra = 0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((j % 16) / 4));
      if (kp_col !== exp_col) bad_col++;
      if (j == 1) begin
        clear = 1'b0;
        obs_v = key_valid; obs_code = key_code; obs_entry = entry_value;
        e = exp_q.pop_front();
        chk("key_valid", 32'(key_valid), 32'(e[20]));
        chk("key_code", 32'(key_code), 32'(e[19:16]));
        chk("entry_value", 32'(entry_value), 32'(e[15:0]));
      end else if (key_valid !== 1'b0) begin
        extra++;
      end
    end
    chk("kp_col_sequence", 32'(bad_col), 32'd0);
    chk("no_stray_valid", 32'(extra), 32'd0);
    prev_keys = k;
    prev_valid = 1;
  endtask

  // Leaves the bench aligned as if the last reset edge had started column 0.
  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_kp_col", 32'(kp_col), 32'hE);
    chk("reset_entry", 32'(entry_value), 32'h0);
    chk("reset_valid", 32'(key_valid), 32'h0);
    chk("reset_code", 32'(key_code), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press_key(input int k);
    logic v; logic [3:0] cd; logic [15:0] en;
    do_scan(kb(k), 0, v, cd, en);
    do_scan(kb(k), 0, v, cd, en);
    do_scan('0, 0, v, cd, en);
    do_scan('0, 0, v, cd, en);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] k;
    logic        clr;
    logic        v;
    logic [3:0]  code;
    logic [15:0] entry;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] k, input logic v, input logic [3:0] code,
                     input logic [15:0] entry);
    vec_t t;
    t.k = k; t.clr = 0; t.v = v; t.code = code; t.entry = entry;
    tbl.push_back(t);
  endtask

  initial begin
    logic v; logic [3:0] cd; logic [15:0] en;
    int pulses;
    logic [15:0] rk;
    int mode, run;
    logic rclr;

    // Expected outputs in each row are those seen at the start of that row,
    // i.e. the result of the previous row's scan.
    add(kb(5),  0, 4'h0, 16'h0000);
    add(kb(5),  0, 4'h0, 16'h0000);
    add(kb(5),  1, 4'h5, 16'h0005);
    add('0,     0, 4'h5, 16'h0005);
    add('0,     0, 4'h5, 16'h0005);
    add(kb(1),  0, 4'h5, 16'h0005);
    add(kb(1),  0, 4'h5, 16'h0005);
    add('0,     1, 4'h1, 16'h0051);
    add('0,     0, 4'h1, 16'h0051);
    add(kb(2),  0, 4'h1, 16'h0051);
    add(kb(2),  0, 4'h1, 16'h0051);
    add('0,     1, 4'h2, 16'h0512);
    add('0,     0, 4'h2, 16'h0512);
    add(kb(3),  0, 4'h2, 16'h0512);
    add(kb(3),  0, 4'h2, 16'h0512);
    add('0,     1, 4'h3, 16'h5123);
    add('0,     0, 4'h3, 16'h5123);
    add(kb(4),  0, 4'h3, 16'h5123);
    add(kb(4),  0, 4'h3, 16'h5123);
    add('0,     1, 4'h4, 16'h1234);
    add('0,     0, 4'h4, 16'h1234);
    add(kb(10), 0, 4'h4, 16'h1234);
    add(kb(10), 0, 4'h4, 16'h1234);
    add('0,     1, 4'hA, 16'h234A);
    add('0,     0, 4'hA, 16'h234A);
    add(kb(7),  0, 4'hA, 16'h234A);   // one-scan press
    add('0,     0, 4'hA, 16'h234A);
    add(kb(8),  0, 4'hA, 16'h234A);   // one-scan bounce
    add('0,     0, 4'hA, 16'h234A);
    for (int i = 0; i < 5; i++) add(kb(1) | kb(2), 0, 4'hA, 16'h234A);
    add('0,     0, 4'hA, 16'h234A);
    add('0,     0, 4'hA, 16'h234A);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      do_scan(tbl[i].k, tbl[i].clr, v, cd, en);
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_code", i), 32'(cd), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_entry", i), 32'(en), 32'(tbl[i].entry));
    end

    // Hold F for 10 scans with E also down on scans 4-6.
    pulses = 0;
    for (int s = 1; s <= 13; s++) begin
      rk = (s <= 10) ? kb(15) : 16'h0;
      if (s >= 4 && s <= 6) rk = rk | kb(14);
      do_scan(rk, 0, v, cd, en);
      pulses += int'(v);
    end
    chk("f_hold_pulses", 32'(pulses), 32'd1);
    chk("f_hold_code", 32'(key_code), 32'hF);
    chk("f_hold_entry", 32'(entry_value), 32'h34AF);

    // Clear coinciding with the accept of key 9.
    press_key(10); press_key(11); press_key(12); press_key(13);
    chk("abcd_entry", 32'(entry_value), 32'hABCD);
    do_scan(kb(9), 0, v, cd, en);
    do_scan(kb(9), 0, v, cd, en);
    do_scan('0, 1, v, cd, en);
    chk("clear_acc_valid", 32'(v), 32'd1);
    chk("clear_acc_code", 32'(cd), 32'h9);
    chk("clear_acc_entry", 32'(en), 32'h0);
    do_scan('0, 0, v, cd, en);

    // Reset in the middle of debouncing key 3.
    do_scan(kb(3), 0, v, cd, en);
    do_scan(kb(3), 0, v, cd, en);
    do_reset();
    pulses = 0;
    do_scan(kb(3), 0, v, cd, en); pulses += int'(v);
    do_scan('0, 0, v, cd, en);    pulses += int'(v);
    do_scan('0, 0, v, cd, en);    pulses += int'(v);
    chk("rst_debounce_pulses", 32'(pulses), 32'd0);
    do_scan(kb(3), 0, v, cd, en);
    do_scan(kb(3), 0, v, cd, en);
    do_scan('0, 0, v, cd, en);
    chk("rst_redebounce_valid", 32'(v), 32'd1);
    chk("rst_redebounce_entry", 32'(en), 32'h0003);
    do_scan('0, 0, v, cd, en);

    // Randomized key activity checked against the model.
    for (int n = 0; n < 120; n++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 3)      rk = 16'h0;
      else if (mode <= 8) rk = kb($urandom_range(0, 15));
      else                rk = kb($urandom_range(0, 15)) | kb($urandom_range(0, 15));
      run = $urandom_range(1, 4);
      for (int r = 0; r < run; r++) begin
        rclr = ($urandom_range(0, 15) == 0);
        do_scan(rk, rclr, v, cd, en);
      end
    end
    for (int n = 0; n < 3; n++) do_scan('0, 0, v, cd, en);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
